// File: rtl/q8_8_accumulator.sv
// Sums sign-magnitude Q8.8 beats in a two's-complement accumulator and emits a
// 17-bit sign-magnitude block total. Define Q8_8_ACC_SAT_EN to saturate on overflow.
module q8_8_accumulator #(
    parameter int BUS_WIDTH = 16,
    parameter int BLOCK_LEN = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BUS_WIDTH+1:0]   in_data,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BUS_WIDTH:0]     out_data,
    output logic                   out_ovf,
    output logic [CNT_WIDTH-1:0]   out_count
);

    localparam int ACC_W = BUS_WIDTH + 2 + CNT_WIDTH;

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [BUS_WIDTH:0]      out_data_q, out_data_d;
    logic                    out_ovf_q, out_ovf_d;
    logic [CNT_WIDTH-1:0]    out_count_q, out_count_d;

    logic                    accept, close;
    logic [ACC_W-1:0]        beat_mag, abs_mag;
    logic signed [ACC_W-1:0] beat_val, acc_sum;
    logic [CNT_WIDTH-1:0]    cnt_sum;
    logic                    res_sign, res_ovf;
    logic [BUS_WIDTH-1:0]    res_mag;

    // Handshake outputs are forced low while reset is held, even mid-HOLD.
    assign in_ready  = ~rst & (state_q != HOLD);
    assign out_valid = ~rst & (state_q == HOLD);
    assign out_data  = rst ? '0 : out_data_q;
    assign out_ovf   = ~rst & out_ovf_q;
    assign out_count = rst ? '0 : out_count_q;

    assign accept = in_valid & in_ready;

    always_comb begin
        beat_mag = ACC_W'(in_data[BUS_WIDTH:0]);
        beat_val = in_data[BUS_WIDTH+1] ? -$signed(beat_mag) : $signed(beat_mag);
        acc_sum  = acc_q + (accept ? beat_val : '0);
        cnt_sum  = cnt_q + CNT_WIDTH'(accept);

        // Sign only set for a strictly negative sum, so zero is always +0.
        res_sign = acc_sum[ACC_W-1];
        abs_mag  = res_sign ? ACC_W'(-acc_sum) : ACC_W'(acc_sum);
        res_ovf  = |abs_mag[ACC_W-1:BUS_WIDTH];
`ifdef Q8_8_ACC_SAT_EN
        res_mag  = res_ovf ? '1 : abs_mag[BUS_WIDTH-1:0];
`else
        res_mag  = abs_mag[BUS_WIDTH-1:0];
`endif
    end

    always_comb begin
        close = 1'b0;
        case (state_q)
            IDLE:    close = accept && (cnt_sum == CNT_WIDTH'(BLOCK_LEN));
            ACCUM:   close = (accept && (cnt_sum == CNT_WIDTH'(BLOCK_LEN))) || flush;
            default: close = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        out_count_d = out_count_q;
        case (state_q)
            IDLE, ACCUM: begin
                acc_d = acc_sum;
                cnt_d = cnt_sum;
                if (close) begin
                    state_d     = HOLD;
                    out_data_d  = {res_sign, res_mag};
                    out_ovf_d   = res_ovf;
                    out_count_d = cnt_sum;
                end else if (accept) begin
                    state_d = ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            out_count_q <= out_count_d;
        end
    end

endmodule
